// File: rtl/oled_pkg.sv
// Shared types and width helpers for the SSD1306 SPI transmitter.
// Pure declarations; no logic.
package oled_pkg;

   typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} oled_state_e;

   localparam logic OLED_DC_CMD  = 1'b0;
   localparam logic OLED_DC_DATA = 1'b1;

   // Bits needed to hold values 0..max_val, never narrower than one bit.
   function automatic int cnt_w(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/oled_sck_gen.sv
// SCK half-period divider: registered SCK level plus rise/fall strobes that flag the edge
// on which SCK will toggle. Held at zero, SCK low, whenever en is low.
module oled_sck_gen
   import oled_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic sck,
   output logic sck_rise,
   output logic sck_fall
);

   localparam int DIV_W = cnt_w(CLK_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic             sck_q, sck_d;
   logic             wrap;

   always_comb begin
      wrap      = en && (div_cnt_q == DIV_LAST);
      div_cnt_d = div_cnt_q;
      sck_d     = sck_q;
      if (!en) begin
         div_cnt_d = '0;
         sck_d     = 1'b0;
      end else if (wrap) begin
         div_cnt_d = '0;
         sck_d     = ~sck_q;
      end else begin
         div_cnt_d = div_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt_q <= '0;
         sck_q     <= 1'b0;
      end else begin
         div_cnt_q <= div_cnt_d;
         sck_q     <= sck_d;
      end
   end

   assign sck      = sck_q;
   assign sck_rise = wrap & ~sck_q;
   assign sck_fall = wrap & sck_q;

endmodule

// File: rtl/oled_spi_tx.sv
// SPI mode-0 byte transmitter for the SSD1306: MSB first, CS held across back-to-back bytes.
// in_ready only in IDLE/HOLD; a byte taken in HOLD skips CS setup and starts shifting next cycle.
module oled_spi_tx
   import oled_pkg::*;
#(
   parameter int CLK_DIV  = 4,
   parameter int CS_SETUP = 2,
   parameter int CS_HOLD  = 2
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   input  logic       in_dc,
   output logic       in_ready,
   output logic       tx_done,
   output logic       busy,
   output logic       oled_sck,
   output logic       oled_mosi,
   output logic       oled_dc,
   output logic       oled_cs
);

   localparam int CNT_W = cnt_w(max2(CS_SETUP, CS_HOLD));
   localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);

   oled_state_e      state_q, state_d;
   logic [7:0]       shift_q, shift_d;
   logic [2:0]       bit_cnt_q, bit_cnt_d;
   logic             bit_end_q, bit_end_d;
   logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
   logic             cs_q, cs_d, busy_q, busy_d, mosi_q, mosi_d, dc_q, dc_d, done_q, done_d;
   logic             sck_en, sck_rise, sck_fall, accept;

   assign in_ready = (state_q == IDLE) || (state_q == HOLD);
   assign accept   = in_valid && in_ready;
   assign sck_en   = (state_q == SHIFT);

   oled_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
      .clk      (sys_clk),
      .rst_n    (sys_rst_n),
      .en       (sck_en),
      .sck      (oled_sck),
      .sck_rise (sck_rise),
      .sck_fall (sck_fall)
   );

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      bit_end_d  = bit_end_q;
      hold_cnt_d = hold_cnt_q;
      cs_d       = cs_q;
      busy_d     = busy_q;
      mosi_d     = mosi_q;
      dc_d       = dc_q;
      done_d     = 1'b0;
      if (accept) begin
         shift_d    = in_data;
         mosi_d     = in_data[7];
         dc_d       = in_dc;
         bit_cnt_d  = '0;
         bit_end_d  = 1'b0;
         hold_cnt_d = '0;
      end
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = SETUP;
               cs_d    = 1'b0;
               busy_d  = 1'b1;
            end
         end
         SETUP: begin
            if (hold_cnt_q == SETUP_LAST) begin
               state_d   = SHIFT;
               bit_cnt_d = '0;
               bit_end_d = 1'b0;
            end else begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
         end
         SHIFT: begin
            // The end flag is armed on the 8th rise so the 3-bit count may wrap on the 8th fall.
            if (sck_rise && (bit_cnt_q == 3'd7)) bit_end_d = 1'b1;
            if (sck_fall) begin
               shift_d   = {shift_q[6:0], 1'b0};
               mosi_d    = shift_q[6];
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_end_q) begin
                  state_d    = HOLD;
                  done_d     = 1'b1;
                  hold_cnt_d = '0;
               end
            end
         end
         HOLD: begin
            if (accept) begin
               state_d = SHIFT;
            end else if (hold_cnt_q == HOLD_LAST) begin
               state_d = IDLE;
               cs_d    = 1'b1;
               busy_d  = 1'b0;
            end else begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         bit_end_q  <= 1'b0;
         hold_cnt_q <= '0;
         cs_q       <= 1'b1;
         busy_q     <= 1'b0;
         mosi_q     <= 1'b0;
         dc_q       <= OLED_DC_CMD;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         bit_cnt_q  <= bit_cnt_d;
         bit_end_q  <= bit_end_d;
         hold_cnt_q <= hold_cnt_d;
         cs_q       <= cs_d;
         busy_q     <= busy_d;
         mosi_q     <= mosi_d;
         dc_q       <= dc_d;
         done_q     <= done_d;
      end
   end

   assign oled_cs   = cs_q;
   assign busy      = busy_q;
   assign oled_mosi = mosi_q;
   assign oled_dc   = dc_q;
   assign tx_done   = done_q;

endmodule

// File: tb/tb_oled_spi_tx.sv
// Scoreboard bench: the driver pushes per-byte expectations (bits, D/C, tx_done cycle) derived
// from the timing rules; monitors reassemble bytes from SCK rises and compare on each tx_done.
module tb_oled_spi_tx;
   import oled_pkg::*;

   localparam int D = 2, S = 2, H = 3;
   localparam int DB = 1, SB = 1, HB = 1;

   logic sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   int cyc = 0;
   always @(posedge sys_clk) cyc <= cyc + 1;

   logic       rst_a_n, in_valid, in_dc, in_ready, tx_done, busy, oled_sck, oled_mosi, oled_dc, oled_cs;
   logic [7:0] in_data;
   logic       rst_b_n, vb, dcb, rdy_b, done_b, busy_b, sck_b, mosi_b, dc_b, cs_b;
   logic [7:0] db;

   oled_spi_tx #(.CLK_DIV(D), .CS_SETUP(S), .CS_HOLD(H)) dut_a (
      .sys_clk(sys_clk), .sys_rst_n(rst_a_n), .in_valid(in_valid), .in_data(in_data), .in_dc(in_dc),
      .in_ready(in_ready), .tx_done(tx_done), .busy(busy), .oled_sck(oled_sck),
      .oled_mosi(oled_mosi), .oled_dc(oled_dc), .oled_cs(oled_cs));

   oled_spi_tx #(.CLK_DIV(DB), .CS_SETUP(SB), .CS_HOLD(HB)) dut_b (
      .sys_clk(sys_clk), .sys_rst_n(rst_b_n), .in_valid(vb), .in_data(db), .in_dc(dcb),
      .in_ready(rdy_b), .tx_done(done_b), .busy(busy_b), .oled_sck(sck_b),
      .oled_mosi(mosi_b), .oled_dc(dc_b), .oled_cs(cs_b));

   typedef struct {logic [7:0] data; logic dc; int done_cyc;} exp_t;
   exp_t q[$];
   exp_t qb[$];

   int total = 0, bad = 0;

   // Reference timeline for dut_a, in absolute cycle numbers.
   int   last_t0 = -100, last_done = -100, cs_lo_from = -100, cs_lo_until = -100;
   logic last_dc = 1'b0, prev_dc = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: actual=%0d required=%0d at cycle %0d", name, act, exp, cyc);
      end
   endtask

   task automatic reset_model();
      q.delete();
      last_t0 = -100; last_done = -100; cs_lo_from = -100; cs_lo_until = -100;
      last_dc = 1'b0; prev_dc = 1'b0;
   endtask

   task automatic send_a(input logic [7:0] d, input logic dc, input bit keep);
      int  n;
      int  t0, dn;
      bit  from_idle;
      in_valid = 1'b1; in_data = d; in_dc = dc; n = 0;
      @(negedge sys_clk);
      while (!in_ready && n < 400) begin
         n++;
         @(negedge sys_clk);
      end
      if (!in_ready) begin
         chk("accept_timeout", in_ready, 1);
         in_valid = 1'b0;
      end else begin
         t0 = cyc;
         from_idle = (t0 > cs_lo_until);
         dn = t0 + 1 + (from_idle ? S : 0) + 16 * D;
         if (from_idle) cs_lo_from = t0 + 1;
         cs_lo_until = dn + H - 1;
         prev_dc = last_dc; last_dc = dc; last_t0 = t0; last_done = dn;
         q.push_back('{data: d, dc: dc, done_cyc: dn});
         @(posedge sys_clk); #1;
         if (!keep) in_valid = 1'b0;
      end
   endtask

   // Idle the request line until the given cycle, scribbling junk on data/dc meanwhile.
   task automatic wait_until(input int target);
      while (cyc < target) begin
         in_data = 8'($urandom); in_dc = 1'($urandom_range(0, 1));
         @(posedge sys_clk); #1;
      end
   endtask

   task automatic drain_a();
      int n = 0;
      while ((q.size() != 0 || cyc <= cs_lo_until + 1) && n < 3000) begin
         n++;
         @(negedge sys_clk);
      end
      if (q.size() != 0) chk("drain_queue", q.size(), 0);
      @(posedge sys_clk); #1;
   endtask

   // dut_a monitor
   int         nrise = 0, dc_bad = 0, tm_bad = 0, exp_rise;
   logic [7:0] col = '0;
   logic       prev_sck = 1'b0;
   bit         exp_lo;
   exp_t       e;

   always @(negedge sys_clk) begin
      if (!rst_a_n) begin
         nrise = 0; col = '0; dc_bad = 0; tm_bad = 0; prev_sck = 1'b0;
      end else begin
         exp_lo = (cyc >= cs_lo_from) && (cyc <= cs_lo_until);
         chk("cs", oled_cs, !exp_lo);
         chk("busy", busy, exp_lo);
         chk("in_ready", in_ready, !(cyc > last_t0 && cyc < last_done));
         chk("dc", oled_dc, (cyc > last_t0) ? last_dc : prev_dc);
         if (!exp_lo) chk("sck_idle", oled_sck, 0);
         if (oled_sck && !prev_sck) begin
            if (q.size() == 0) chk("stray_rise", oled_sck, 0);
            else begin
               nrise++;
               col = {col[6:0], oled_mosi};
               exp_rise = q[0].done_cyc - 16 * D + (2 * nrise - 1) * D;
               if (cyc != exp_rise) tm_bad++;
               if (oled_dc !== q[0].dc || oled_cs !== 1'b0) dc_bad++;
            end
         end
         if (tx_done) begin
            if (q.size() == 0) chk("unexpected_done", tx_done, 0);
            else begin
               e = q.pop_front();
               chk("done_cycle", cyc, e.done_cyc);
               chk("byte", col, e.data);
               chk("rise_count", nrise, 8);
               chk("dc_cs_at_rise", dc_bad, 0);
               chk("rise_timing", tm_bad, 0);
               nrise = 0; col = '0; dc_bad = 0; tm_bad = 0;
            end
         end else if (q.size() != 0 && cyc > q[0].done_cyc) begin
            chk("missed_done", tx_done, 1);
            q.delete(0);
            nrise = 0; col = '0; dc_bad = 0; tm_bad = 0;
         end
         prev_sck = oled_sck;
      end
   end

   // dut_b monitor: minimum divider, sends only from idle
   int         nrb = 0, perb = 0, last_rise_b = -100, rel_b = -1;
   logic [7:0] colb = '0;
   logic       prev_sck_b = 1'b0;
   exp_t       eb;

   always @(negedge sys_clk) begin
      if (rst_b_n) begin
         if (sck_b && !prev_sck_b) begin
            nrb++;
            colb = {colb[6:0], mosi_b};
            if (nrb > 1 && cyc != last_rise_b + 2 * DB) perb++;
            if (nrb == 1 && qb.size() != 0 && cyc != qb[0].done_cyc - 16 * DB + DB) perb++;
            if (cs_b !== 1'b0) perb++;
            last_rise_b = cyc;
         end
         if (done_b) begin
            if (qb.size() == 0) chk("b_unexpected_done", done_b, 0);
            else begin
               eb = qb.pop_front();
               chk("b_done_cycle", cyc, eb.done_cyc);
               chk("b_byte", colb, eb.data);
               chk("b_rise_count", nrb, 8);
               chk("b_sck_period", perb, 0);
               rel_b = cyc + HB;
               nrb = 0; colb = '0; perb = 0;
            end
         end
         if (cyc == rel_b) chk("b_cs_release", cs_b, 1);
         prev_sck_b = sck_b;
      end
   end

   bit b_finished = 0;

   task automatic send_b(input logic [7:0] d);
      int n = 0;
      vb = 1'b1; db = d; dcb = OLED_DC_DATA;
      @(negedge sys_clk);
      while (!rdy_b && n < 200) begin
         n++;
         @(negedge sys_clk);
      end
      if (!rdy_b) chk("b_accept_timeout", rdy_b, 1);
      else qb.push_back('{data: d, dc: OLED_DC_DATA, done_cyc: cyc + 1 + SB + 16 * DB});
      @(posedge sys_clk); #1;
      vb = 1'b0;
      n = 0;
      while (qb.size() != 0 && n < 200) begin
         n++;
         @(posedge sys_clk);
      end
      repeat (4) @(posedge sys_clk);
      #1;
   endtask

   initial begin
      vb = 1'b0; db = '0; dcb = 1'b0;
      wait (rst_b_n === 1'b1);
      repeat (5) @(posedge sys_clk);
      #1;
      send_b(8'hFF);
      send_b(8'($urandom));
      b_finished = 1;
   end

   initial begin
      int n;
      logic [7:0] d;
      logic dc;
      bit keep;
      in_valid = 1'b0; in_data = '0; in_dc = 1'b0;
      rst_a_n = 1'b0; rst_b_n = 1'b0;
      repeat (3) @(posedge sys_clk);
      #1;
      chk("rst_cs", oled_cs, 1);     chk("rst_sck", oled_sck, 0);  chk("rst_mosi", oled_mosi, 0);
      chk("rst_dc", oled_dc, 0);     chk("rst_done", tx_done, 0);  chk("rst_busy", busy, 0);
      chk("rst_ready", in_ready, 1);
      #1; rst_a_n = 1'b1; rst_b_n = 1'b1;
      repeat (2) @(posedge sys_clk);
      #1;

      // single command byte
      send_a(8'hAE, OLED_DC_CMD, 0);
      drain_a();

      // second byte first presented in the HOLD cycle of the first
      send_a(8'hAE, OLED_DC_CMD, 0);
      wait_until(last_done);
      send_a(8'h55, OLED_DC_DATA, 0);
      drain_a();

      // valid held high with the next byte while the first is shifting
      send_a(8'h80, OLED_DC_CMD, 1);
      send_a(8'h12, OLED_DC_CMD, 0);
      drain_a();

      // reset after the third rise drops the byte silently
      send_a(8'hC3, OLED_DC_DATA, 0);
      n = 0;
      while (nrise < 3 && n < 200) begin
         n++;
         @(negedge sys_clk);
      end
      if (nrise < 3) chk("reset_wait_rise", nrise, 3);
      #2;
      rst_a_n = 1'b0;
      reset_model();
      #1;
      chk("arst_cs", oled_cs, 1);    chk("arst_sck", oled_sck, 0); chk("arst_ready", in_ready, 1);
      chk("arst_done", tx_done, 0);  chk("arst_busy", busy, 0);
      repeat (3) @(posedge sys_clk);
      #2;
      rst_a_n = 1'b1;
      @(posedge sys_clk); #1;
      send_a(8'h00, OLED_DC_CMD, 0);
      drain_a();

      // init stream: 26 commands then 26 data bytes, valid never drops
      for (int i = 0; i < 52; i++) begin
         dc = (i >= 26) ? OLED_DC_DATA : OLED_DC_CMD;
         send_a(8'($urandom), dc, i < 51);
      end
      drain_a();

      // random bytes arriving at random points in HOLD or IDLE
      for (int i = 0; i < 40; i++) begin
         d = 8'($urandom);
         dc = 1'($urandom_range(0, 1));
         keep = ($urandom_range(0, 3) == 0);
         send_a(d, dc, keep);
         if (!keep) wait_until(last_done + $urandom_range(0, 5));
      end
      in_valid = 1'b0;
      drain_a();

      n = 0;
      while (!b_finished && n < 2000) begin
         n++;
         @(posedge sys_clk);
      end
      if (!b_finished) chk("b_finish_timeout", b_finished, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
